// File: rtl/vp_lvp_table.sv
// ----------------------------------------------------------------------------
// vp_lvp_table
//   Multi-lane last-value prediction table. Each direct-mapped entry holds a
//   tag, the last committed result and a saturating confidence counter.
//   Decode looks up by PC and receives a registered prediction one cycle
//   later. Commit trains the table with the actual result. It also counts
//   used-and-mispredicted events for the PMU.
//
// Ports
//   clk, rst_l      core clock, asynchronous active-low reset
//   flush           invalidate every entry at the next edge
//   lkp_valid/pc    per-lane lookup request, PC[31:1]
//   pred_valid      registered hit per lane
//   pred_conf       registered hit with confidence >= CONF_THRESH
//   pred_result     registered predicted value per lane (0 on miss)
//   upd_valid/pc    per-lane commit training request, PC[31:1]
//   upd_result      actual committed result
//   upd_misp        prediction was confident and wrong
//   upd_used        a dependent consumed the prediction
//   misp_cnt        saturating count of valid&used&misp training events
// ----------------------------------------------------------------------------
module vp_lvp_table #(
    parameter int NUM_LANES   = 2,
    parameter int ENTRIES     = 64,
    parameter int TAG_W       = 8,
    parameter int DATA_W      = 32,
    parameter int CONF_W      = 3,
    parameter int CONF_THRESH = 6
) (
    input  logic                        clk,
    input  logic                        rst_l,
    input  logic                        flush,
    input  logic [NUM_LANES-1:0]        lkp_valid,
    input  logic [NUM_LANES*31-1:0]     lkp_pc,
    output logic [NUM_LANES-1:0]        pred_valid,
    output logic [NUM_LANES-1:0]        pred_conf,
    output logic [NUM_LANES*DATA_W-1:0] pred_result,
    input  logic [NUM_LANES-1:0]        upd_valid,
    input  logic [NUM_LANES*31-1:0]     upd_pc,
    input  logic [NUM_LANES*DATA_W-1:0] upd_result,
    input  logic [NUM_LANES-1:0]        upd_misp,
    input  logic [NUM_LANES-1:0]        upd_used,
    output logic [15:0]                 misp_cnt
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam logic [CONF_W-1:0] CONF_TH = CONF_W'(CONF_THRESH);

    // The pc ports carry PC[31:1], so PC bit n sits at port bit n-1.
    function automatic logic [IDX_W-1:0] pc_idx(input logic [30:0] pc);
        return pc[IDX_W-1:0];
    endfunction

    function automatic logic [TAG_W-1:0] pc_tag(input logic [30:0] pc);
        return pc[IDX_W+TAG_W-1:IDX_W];
    endfunction

    function automatic logic [CONF_W-1:0] sat_inc_conf(input logic [CONF_W-1:0] c);
        return (c == {CONF_W{1'b1}}) ? c : c + 1'b1;
    endfunction

    function automatic logic [15:0] sat_cnt(input logic [16:0] s);
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    // Table storage: valid and confidence are control state and are reset.
    // Tag and data are qualified by valid, so they are left unreset.
    logic [ENTRIES-1:0] vld_mem;
    logic [CONF_W-1:0]  conf_mem [ENTRIES];
    logic [TAG_W-1:0]   tag_mem  [ENTRIES];
    logic [DATA_W-1:0]  data_mem [ENTRIES];

    // Registered lookup results.
    logic [NUM_LANES-1:0]             vld_p0;
    logic [NUM_LANES-1:0]             conf_p0;
    logic [NUM_LANES-1:0][DATA_W-1:0] result_p0;
    logic [15:0]                      misp_cnt_p0;

    // Combinational lookup and update evaluation.
    logic [NUM_LANES-1:0]             lk_hit;
    logic [NUM_LANES-1:0]             lk_conf;
    logic [NUM_LANES-1:0][DATA_W-1:0] lk_data;
    logic [NUM_LANES-1:0]             upd_we;
    logic [NUM_LANES-1:0][CONF_W-1:0] nxt_conf;
    logic [NUM_LANES-1:0][DATA_W-1:0] nxt_data;
    logic [16:0]                      cnt_sum;

    // Only the index and tag bits of the PCs take part in the lookup.
    logic unused_pc;
    assign unused_pc = ^{lkp_pc, upd_pc};

    // Lookup reads the pre-update contents. Lanes without a request produce
    // zeros and never index the arrays with their possibly-unknown PC.
    always_comb begin
        for (int l = 0; l < NUM_LANES; l++) begin
            lk_hit[l]  = 1'b0;
            lk_conf[l] = 1'b0;
            lk_data[l] = '0;
            if (lkp_valid[l]) begin
                if (vld_mem[pc_idx(lkp_pc[l*31 +: 31])] &&
                    (tag_mem[pc_idx(lkp_pc[l*31 +: 31])] == pc_tag(lkp_pc[l*31 +: 31]))) begin
                    lk_hit[l]  = 1'b1;
                    lk_data[l] = data_mem[pc_idx(lkp_pc[l*31 +: 31])];
                    lk_conf[l] = (conf_mem[pc_idx(lkp_pc[l*31 +: 31])] >= CONF_TH);
                end
            end
        end
    end

    // Training: a lane writes only when no younger valid lane targets the
    // same index, so the youngest update alone takes effect.
    always_comb begin
        for (int l = 0; l < NUM_LANES; l++) begin
            upd_we[l]   = upd_valid[l];
            nxt_conf[l] = '0;
            nxt_data[l] = '0;
            for (int m = l + 1; m < NUM_LANES; m++) begin
                if (upd_valid[m] &&
                    (pc_idx(upd_pc[m*31 +: 31]) == pc_idx(upd_pc[l*31 +: 31]))) begin
                    upd_we[l] = 1'b0;
                end
            end
            if (upd_valid[l]) begin
                nxt_data[l] = upd_result[l*DATA_W +: DATA_W];
                // Only a hit that is not flagged mispredicted and whose
                // result matches keeps the data and gains confidence.
                // Every other case leaves confidence at zero.
                if (vld_mem[pc_idx(upd_pc[l*31 +: 31])] &&
                    (tag_mem[pc_idx(upd_pc[l*31 +: 31])] == pc_tag(upd_pc[l*31 +: 31])) &&
                    !(upd_used[l] && upd_misp[l]) &&
                    (upd_result[l*DATA_W +: DATA_W] == data_mem[pc_idx(upd_pc[l*31 +: 31])])) begin
                    nxt_conf[l] = sat_inc_conf(conf_mem[pc_idx(upd_pc[l*31 +: 31])]);
                end
            end
        end
    end

    always_comb begin
        cnt_sum = {1'b0, misp_cnt_p0};
        for (int l = 0; l < NUM_LANES; l++) begin
            if (upd_valid[l] && upd_used[l] && upd_misp[l]) begin
                cnt_sum = cnt_sum + 17'd1;
            end
        end
    end

    // ---- stage p0: table control state, registered lookup, PMU count ----
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            vld_mem     <= '0;
            vld_p0      <= '0;
            conf_p0     <= '0;
            result_p0   <= '0;
            misp_cnt_p0 <= '0;
            for (int e = 0; e < ENTRIES; e++) begin
                conf_mem[e] <= '0;
            end
        end else begin
            vld_p0      <= lk_hit;
            conf_p0     <= lk_conf;
            result_p0   <= lk_data;
            misp_cnt_p0 <= sat_cnt(cnt_sum);
            if (flush) begin
                vld_mem <= '0;
                for (int e = 0; e < ENTRIES; e++) begin
                    conf_mem[e] <= '0;
                end
            end else begin
                for (int l = 0; l < NUM_LANES; l++) begin
                    if (upd_we[l]) begin
                        vld_mem[pc_idx(upd_pc[l*31 +: 31])]  <= 1'b1;
                        conf_mem[pc_idx(upd_pc[l*31 +: 31])] <= nxt_conf[l];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!flush) begin
            for (int l = 0; l < NUM_LANES; l++) begin
                if (upd_we[l]) begin
                    tag_mem[pc_idx(upd_pc[l*31 +: 31])]  <= pc_tag(upd_pc[l*31 +: 31]);
                    data_mem[pc_idx(upd_pc[l*31 +: 31])] <= nxt_data[l];
                end
            end
        end
    end

    assign pred_valid  = vld_p0;
    assign pred_conf   = conf_p0;
    assign pred_result = result_p0;
    assign misp_cnt    = misp_cnt_p0;

endmodule

// File: tb/tb_vp_lvp_table.sv
// ----------------------------------------------------------------------------
// tb_vp_lvp_table
//   Directed bench for vp_lvp_table (default parameters). Lookups push their
//   expected prediction onto a scoreboard queue; after the following edge the
//   queue is drained and compared against the registered outputs.
// ----------------------------------------------------------------------------
module tb_vp_lvp_table;

    localparam int NL = 2;
    localparam int DW = 32;

    logic              clk = 1'b0;
    logic              rst_l;
    logic              flush;
    logic [NL-1:0]     lkp_valid;
    logic [NL*31-1:0]  lkp_pc;
    logic [NL-1:0]     pred_valid;
    logic [NL-1:0]     pred_conf;
    logic [NL*DW-1:0]  pred_result;
    logic [NL-1:0]     upd_valid;
    logic [NL*31-1:0]  upd_pc;
    logic [NL*DW-1:0]  upd_result;
    logic [NL-1:0]     upd_misp;
    logic [NL-1:0]     upd_used;
    logic [15:0]       misp_cnt;

    always #5 clk = ~clk;

    vp_lvp_table dut (
        .clk         (clk),
        .rst_l       (rst_l),
        .flush       (flush),
        .lkp_valid   (lkp_valid),
        .lkp_pc      (lkp_pc),
        .pred_valid  (pred_valid),
        .pred_conf   (pred_conf),
        .pred_result (pred_result),
        .upd_valid   (upd_valid),
        .upd_pc      (upd_pc),
        .upd_result  (upd_result),
        .upd_misp    (upd_misp),
        .upd_used    (upd_used),
        .misp_cnt    (misp_cnt)
    );

    typedef struct {
        int          lane;
        logic        v;
        logic        c;
        logic [31:0] r;
        string       tag;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        flush      = 1'b0;
        lkp_valid  = '0;
        lkp_pc     = '0;
        upd_valid  = '0;
        upd_pc     = '0;
        upd_result = '0;
        upd_misp   = '0;
        upd_used   = '0;
    endtask

    // Issue a lookup (full byte PC) and queue the prediction it must produce.
    task automatic lk(input int lane, input logic [31:0] pc, input logic v,
                      input logic c, input logic [31:0] r, input string tag);
        exp_t e;
        lkp_valid[lane]        = 1'b1;
        lkp_pc[lane*31 +: 31]  = pc[31:1];
        e.lane = lane;
        e.v    = v;
        e.c    = c;
        e.r    = r;
        e.tag  = tag;
        sbq.push_back(e);
    endtask

    task automatic up(input int lane, input logic [31:0] pc, input logic [31:0] res,
                      input logic used, input logic misp);
        upd_valid[lane]            = 1'b1;
        upd_pc[lane*31 +: 31]      = pc[31:1];
        upd_result[lane*DW +: DW]  = res;
        upd_used[lane]             = used;
        upd_misp[lane]             = misp;
    endtask

    // Clock once, then compare every prediction queued for this edge.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk({e.tag, "_valid"},  32'(pred_valid[e.lane]), 32'(e.v));
            chk({e.tag, "_conf"},   32'(pred_conf[e.lane]),  32'(e.c));
            chk({e.tag, "_result"}, pred_result[e.lane*DW +: DW], e.r);
        end
        idle();
    endtask

    initial begin
        idle();
        rst_l = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid",  32'(pred_valid), 32'd0);
        chk("rst_result", pred_result[31:0], 32'd0);
        chk("rst_misp",   32'(misp_cnt), 32'd0);
        rst_l = 1'b1;

        // Cold lookup misses.
        lk(0, 32'h100, 1'b0, 1'b0, 32'h0, "cold");
        tick();
        chk("cold_misp", 32'(misp_cnt), 32'd0);

        // Six trainings: allocate then five hits -> confidence 5.
        for (int i = 0; i < 6; i++) begin
            up(0, 32'h100, 32'hDEADBEEF, 1'b0, 1'b0);
            tick();
        end
        lk(0, 32'h100, 1'b1, 1'b0, 32'hDEADBEEF, "conf5");
        tick();
        up(0, 32'h100, 32'hDEADBEEF, 1'b0, 1'b0);
        tick();
        lk(0, 32'h100, 1'b1, 1'b1, 32'hDEADBEEF, "conf6");
        tick();

        // Unknown PCs with valid low must leave both lanes at zero.
        lkp_pc     = 'x;
        upd_pc     = 'x;
        upd_result = 'x;
        begin
            exp_t e;
            for (int l = 0; l < NL; l++) begin
                e.lane = l; e.v = 1'b0; e.c = 1'b0; e.r = 32'h0; e.tag = "xpc";
                sbq.push_back(e);
            end
        end
        tick();

        // Three more hits: 6 -> 7 -> 7 -> 7, still confident.
        for (int i = 0; i < 3; i++) begin
            up(0, 32'h100, 32'hDEADBEEF, 1'b0, 1'b0);
            tick();
        end
        lk(0, 32'h100, 1'b1, 1'b1, 32'hDEADBEEF, "sat7");
        tick();

        // Used mispredict: data replaced, confidence cleared, counted.
        up(0, 32'h100, 32'h1, 1'b1, 1'b1);
        tick();
        chk("misp_cnt1", 32'(misp_cnt), 32'd1);
        lk(0, 32'h100, 1'b1, 1'b0, 32'h1, "after_misp");
        tick();

        // Rebuild confidence on 0x1, then an unflagged different result.
        for (int i = 0; i < 6; i++) begin
            up(0, 32'h100, 32'h1, 1'b0, 1'b0);
            tick();
        end
        lk(0, 32'h100, 1'b1, 1'b1, 32'h1, "retrain");
        tick();
        up(0, 32'h100, 32'h2, 1'b1, 1'b0);
        tick();
        lk(0, 32'h100, 1'b1, 1'b0, 32'h2, "diff_res");
        tick();
        up(0, 32'h100, 32'h3, 1'b0, 1'b1);
        tick();
        chk("misp_unused", 32'(misp_cnt), 32'd1);

        // Same index on both lanes: the younger lane alone writes.
        up(0, 32'h100, 32'hAAAA, 1'b0, 1'b0);
        up(1, 32'h180, 32'hBBBB, 1'b0, 1'b0);
        tick();
        lk(0, 32'h100, 1'b0, 1'b0, 32'h0,    "dup_old");
        lk(1, 32'h180, 1'b1, 1'b0, 32'hBBBB, "dup_young");
        tick();

        // Distinct indices on both lanes, both counted as used mispredicts.
        up(0, 32'h104, 32'h11, 1'b1, 1'b1);
        up(1, 32'h108, 32'h22, 1'b1, 1'b1);
        tick();
        chk("misp_cnt3", 32'(misp_cnt), 32'd3);
        lk(0, 32'h104, 1'b1, 1'b0, 32'h11, "two_l0");
        lk(1, 32'h108, 1'b1, 1'b0, 32'h22, "two_l1");
        tick();

        // Lookup and update in the same cycle: lookup sees old contents.
        lk(0, 32'h104, 1'b1, 1'b0, 32'h11, "rbw_old");
        up(0, 32'h104, 32'h55, 1'b0, 1'b0);
        tick();
        lk(0, 32'h104, 1'b1, 1'b0, 32'h55, "rbw_new");
        tick();

        // Confident entry, then flush with a concurrent update.
        for (int i = 0; i < 6; i++) begin
            up(0, 32'h108, 32'h22, 1'b0, 1'b0);
            tick();
        end
        flush = 1'b1;
        lk(0, 32'h108, 1'b1, 1'b1, 32'h22, "flush_pre");
        up(1, 32'h108, 32'h99, 1'b1, 1'b1);
        tick();
        chk("flush_misp", 32'(misp_cnt), 32'd4);
        lk(0, 32'h108, 1'b0, 1'b0, 32'h0, "flush_l0");
        lk(1, 32'h104, 1'b0, 1'b0, 32'h0, "flush_l1");
        tick();

        // Asynchronous reset in the middle of training.
        up(0, 32'h100, 32'hCAFE, 1'b0, 1'b0);
        tick();
        up(0, 32'h100, 32'hCAFE, 1'b0, 1'b0);
        tick();
        lk(0, 32'h100, 1'b1, 1'b0, 32'hCAFE, "pre_rst");
        tick();
        rst_l = 1'b0;
        #1;
        chk("arst_valid",  32'(pred_valid), 32'd0);
        chk("arst_result", pred_result[31:0], 32'd0);
        chk("arst_misp",   32'(misp_cnt), 32'd0);
        @(negedge clk);
        rst_l = 1'b1;
        lk(0, 32'h100, 1'b0, 1'b0, 32'h0, "post_rst");
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
